dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, giving storage depth in 32-bit words; addresses wrap modulo MEM_WORDS*4.
REQ-002 SHALL have parameter BLK_LATENCY, default 4, giving cycles from block accept to valid; legal range is 1..15.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock.
REQ-004 SHALL have port RESET, input, 1 bit: asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
REQ-005 SHALL have port data_address_2DM, input, 32 bits: byte address for word and block access.
REQ-006 SHALL have ports MemRead_2DM and MemWrite_2DM, input, 1 bit each: word read and word write strobes.
REQ-007 SHALL have port data_write_2DM, input, 32 bits: word write data.
REQ-008 SHALL have port data_write_size_2DM, input, 2 bits: bytes to write, 1/2/3 mean that many bytes and 0 means 4 bytes.
REQ-009 SHALL have port data_read_fDM, output, 32 bits: word read data.
REQ-010 SHALL have ports dBlkRead and dBlkWrite, input, 1 bit each: block request levels.
REQ-011 SHALL have port block_write_2DM, input, 256 bits: block write data.
REQ-012 SHALL have port block_read_fDM, output, 256 bits: block read data.
REQ-013 SHALL have ports block_read_fDM_valid and block_write_fDM_valid, output, 1 bit each: one-cycle completion pulses.
REQ-014 SHALL have port blk_busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-015 SHALL set data_read_fDM combinationally to the word at data_address_2DM[31:2] when MemRead_2DM=1, and to 0 otherwise; zero latency.
REQ-016 SHALL, on a word write, update only bytes off..min(off+N-1,3) at the rising edge, where off=address[1:0] and N is from data_write_size_2DM.
- Big-endian: the last written byte takes data_write_2DM[7:0]; preceding bytes take successively higher bytes.
- Bytes beyond the word boundary are dropped.
REQ-017 SHALL service word accesses in every FSM state.
REQ-018 SHALL implement the FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-019 SHALL, in IDLE with dBlkRead or dBlkWrite high, latch the request type, block address data_address_2DM[31:5], and (for a write) block_write_2DM, load the counter with BLK_LATENCY-1, and enter BUSY.
REQ-020 SHALL, when both dBlkRead and dBlkWrite are high in IDLE, accept the write and ignore the read.
REQ-021 SHALL decrement the counter each BUSY cycle and enter DONE when it reaches 0, so the valid pulse appears exactly BLK_LATENCY cycles after the accept edge.
REQ-022 SHALL, in DONE for a read, assert block_read_fDM_valid for one cycle with block_read_fDM holding the eight words of the latched block, word 0 in bits [255:224].
REQ-023 SHALL hold block_read_fDM stable until the next read completes.
REQ-024 SHALL, in DONE for a write, commit the latched block to storage at the DONE-exit edge and assert block_write_fDM_valid for the DONE cycle.
REQ-025 SHALL let the block write win over a word write to the same word on the same edge.
REQ-026 SHALL ignore request-level changes while in BUSY or DONE.
REQ-027 SHALL always go from DONE to IDLE; a request still high in IDLE is treated as a new request.

Reset
REQ-028 SHALL, while RESET=0, set the FSM to IDLE, the counter to 0, block_read_fDM to 0, both valid outputs to 0, and blk_busy to 0.
REQ-029 SHALL, on reset mid-operation, abandon the pending block operation without committing a pending write.
REQ-030 SHALL leave storage contents unaffected by reset.

Structure
REQ-031 SHALL take BLK_BITS=256, WORDS_PER_BLK=8, the state encoding, and the size-code constants from shared package mem_pkg.
REQ-032 SHALL place storage in sub-module dmem_array, which provides one combinational word read port, one byte-enabled word write port, one 256-bit block read port, and one 256-bit block write port.

Verification
REQ-033 Word round-trip: write 0xDEADBEEF size 0 at 0x40, read 0x40 -> data_read_fDM=0xDEADBEEF in the same cycle.
REQ-034 Partial write: write 0x000000AB size 1 at 0x41 over 0x11223344 -> read 0x40 returns 0x11AB3344.
REQ-035 Block read latency: with BLK_LATENCY=4, preload 0x100..0x11C with 1..8 and hold dBlkRead at 0x104.
- Required: block_read_fDM_valid pulses exactly 4 cycles after accept.
- Required: block_read_fDM=0x00000001_..._00000008.
REQ-036 Simultaneous requests: dBlkRead=dBlkWrite=1 with data all-0xA5 at 0x200.
- Required: only block_write_fDM_valid pulses.
- Required: a subsequent word read of 0x21C returns 0xA5A5A5A5.
REQ-037 Reset mid-BUSY: start a block write at 0x300, then assert RESET=0 for 1 cycle two cycles later.
- Required: no valid pulse; 0x300 retains its old value; blk_busy=0.
REQ-038 Address wrap: with MEM_WORDS=1024, a word write at 0x1000 is read back at 0x0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder.
//   - block geometry (256-bit blocks of eight 32-bit words)
//   - block FSM state encoding
//   - word-write size codes
//   - word_lanes(): turns (byte offset, size code, write data) into byte enables
//     plus lane-aligned data for a big-endian partial word write.
package mem_pkg;

  localparam int BLK_BITS      = 256;
  localparam int WORDS_PER_BLK = 8;

  // Block FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // data_write_size_2DM codes (bytes written)
  localparam logic [1:0] SZ_WORD = 2'd0;  // 4 bytes
  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;
  localparam logic [1:0] SZ_TRI  = 2'd3;

  typedef struct packed {
    logic [3:0]  be;    // be[j] enables bits [8j+7:8j]
    logic [31:0] data;  // already placed in its byte lanes
  } wlane_t;

  // Big-endian: byte k of a word lives in bits [8*(3-k)+7 : 8*(3-k)].
  // The bytes written are off..off+n-1; the last one gets wdata[7:0] and each
  // earlier one the next higher byte. Bytes past byte 3 fall off the word.
  function automatic wlane_t word_lanes(input logic [1:0]  off,
                                        input logic [1:0]  size,
                                        input logic [31:0] wdata);
    wlane_t r;
    int     n;
    int     last;
    r    = '0;
    n    = (size == SZ_WORD) ? 4 : int'(size);
    last = int'(off) + n - 1;
    for (int k = 0; k < 4; k++) begin
      if (k >= int'(off) && k <= last) begin
        r.be[3-k]             = 1'b1;
        r.data[8*(3-k) +: 8]  = wdata[8*(last-k) +: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word/block storage for dmem_responder.
// Ports:
//   clk          - clock (storage has no reset; contents survive reset)
//   rd_word_i    - word address for the combinational word read port
//   rd_data_o    - word read data
//   wr_en_i      - word write strobe; wr_word_i/wr_be_i/wr_data_i give the
//                  word address, byte enables and lane-aligned data
//   blk_raddr_i  - block address (byte address [31:5]) for the block read port
//   blk_rdata_o  - eight words of that block, word 0 in the top 32 bits
//   blk_we_i     - block write strobe; blk_waddr_i/blk_wdata_i as for reads
// All addresses wrap modulo MEM_WORDS words (MEM_WORDS >= 2).
module dmem_array
  import mem_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic                clk,
  input  logic [29:0]         rd_word_i,
  output logic [31:0]         rd_data_o,
  input  logic                wr_en_i,
  input  logic [29:0]         wr_word_i,
  input  logic [3:0]          wr_be_i,
  input  logic [31:0]         wr_data_i,
  input  logic [26:0]         blk_raddr_i,
  output logic [BLK_BITS-1:0] blk_rdata_o,
  input  logic                blk_we_i,
  input  logic [26:0]         blk_waddr_i,
  input  logic [BLK_BITS-1:0] blk_wdata_i
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0] mem_q [MEM_WORDS];

  function automatic logic [AW-1:0] wrap(input logic [29:0] w);
    return AW'(w % 30'(MEM_WORDS));
  endfunction

  assign rd_data_o = mem_q[wrap(rd_word_i)];

  always_comb begin
    blk_rdata_o = '0;
    for (int i = 0; i < WORDS_PER_BLK; i++) begin
      blk_rdata_o[BLK_BITS-1-32*i -: 32] = mem_q[wrap({blk_raddr_i, 3'(i)})];
    end
  end

  // The block write is issued after the word write so that, when both hit
  // the same word on one edge, the block data is what lands.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int j = 0; j < 4; j++) begin
        if (wr_be_i[j]) mem_q[wrap(wr_word_i)][8*j +: 8] <= wr_data_i[8*j +: 8];
      end
    end
    if (blk_we_i) begin
      for (int i = 0; i < WORDS_PER_BLK; i++) begin
        mem_q[wrap({blk_waddr_i, 3'(i)})] <= blk_wdata_i[BLK_BITS-1-32*i -: 32];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: zero-latency word reads, byte-granular big-endian
// word writes, and fixed-latency 256-bit block reads/writes.
// Ports:
//   CLK, RESET            - clock, asynchronous active-low reset
//   data_address_2DM      - byte address for word and block accesses
//   MemRead_2DM/MemWrite_2DM, data_write_2DM, data_write_size_2DM
//                         - word access strobes, write data, size code
//   data_read_fDM         - word read data (0 when MemRead_2DM is low)
//   dBlkRead/dBlkWrite, block_write_2DM
//                         - block request levels and block write data
//   block_read_fDM        - last completed block read (held until the next)
//   block_read_fDM_valid/block_write_fDM_valid - one-cycle completion pulses
//   blk_busy              - block FSM not idle
//
// Block handshake: there is no ready. A request level sampled high while the
// FSM is IDLE is accepted on that edge; levels are ignored in BUSY and DONE.
// The matching *_valid pulses for exactly one cycle BLK_LATENCY cycles after
// the accept edge. A level still high once back in IDLE is a new request.
// Word accesses are independent of the block FSM and work in every state.
// BLK_LATENCY must lie in 1..15.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int MEM_WORDS   = 1024,
  parameter int BLK_LATENCY = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [31:0]         data_address_2DM,
  input  logic                MemRead_2DM,
  input  logic                MemWrite_2DM,
  input  logic [31:0]         data_write_2DM,
  input  logic [1:0]          data_write_size_2DM,
  output logic [31:0]         data_read_fDM,
  input  logic                dBlkRead,
  input  logic                dBlkWrite,
  input  logic [BLK_BITS-1:0] block_write_2DM,
  output logic [BLK_BITS-1:0] block_read_fDM,
  output logic                block_read_fDM_valid,
  output logic                block_write_fDM_valid,
  output logic                blk_busy
);

  logic [1:0]          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                is_wr_q, is_wr_d;
  logic [26:0]         blk_addr_q, blk_addr_d;
  logic [BLK_BITS-1:0] blk_wdata_q, blk_wdata_d;
  logic [BLK_BITS-1:0] blk_rdata_q, blk_rdata_d;

  logic [31:0]         arr_rdata;
  logic [BLK_BITS-1:0] arr_blk_rdata;
  wlane_t              lanes;

  assign lanes = word_lanes(data_address_2DM[1:0], data_write_size_2DM, data_write_2DM);

  dmem_array #(.MEM_WORDS(MEM_WORDS)) u_array (
    .clk         (CLK),
    .rd_word_i   (data_address_2DM[31:2]),
    .rd_data_o   (arr_rdata),
    .wr_en_i     (MemWrite_2DM),
    .wr_word_i   (data_address_2DM[31:2]),
    .wr_be_i     (lanes.be),
    .wr_data_i   (lanes.data),
    .blk_raddr_i (blk_addr_q),
    .blk_rdata_o (arr_blk_rdata),
    .blk_we_i    (state_q == ST_DONE && is_wr_q),
    .blk_waddr_i (blk_addr_q),
    .blk_wdata_i (blk_wdata_q)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_wr_d     = is_wr_q;
    blk_addr_d  = blk_addr_q;
    blk_wdata_d = blk_wdata_q;
    blk_rdata_d = blk_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (dBlkWrite || dBlkRead) begin
          is_wr_d    = dBlkWrite;  // write wins when both are raised
          blk_addr_d = data_address_2DM[31:5];
          if (dBlkWrite) blk_wdata_d = block_write_2DM;
          cnt_d      = 4'(BLK_LATENCY - 1);
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          // Capture on DONE entry so the data is on the port with the pulse.
          if (!is_wr_q) blk_rdata_d = arr_blk_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
      blk_addr_q  <= '0;
      blk_wdata_q <= '0;
      blk_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_wr_q     <= is_wr_d;
      blk_addr_q  <= blk_addr_d;
      blk_wdata_q <= blk_wdata_d;
      blk_rdata_q <= blk_rdata_d;
    end
  end

  assign data_read_fDM         = MemRead_2DM ? arr_rdata : 32'd0;
  assign block_read_fDM        = blk_rdata_q;
  assign block_read_fDM_valid  = (state_q == ST_DONE) && !is_wr_q;
  assign block_write_fDM_valid = (state_q == ST_DONE) && is_wr_q;
  assign blk_busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int MW  = 1024;
  localparam int LAT = 4;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  addr;
  logic         mem_rd, mem_wr;
  logic [31:0]  wdata;
  logic [1:0]   wsize;
  logic [31:0]  rdata;
  logic         blk_rd, blk_wr;
  logic [255:0] blk_wdata;
  logic [255:0] blk_rdata;
  logic         rd_valid, wr_valid, busy;

  always #5 clk = ~clk;

  dmem_responder #(.MEM_WORDS(MW), .BLK_LATENCY(LAT)) dut (
    .CLK                   (clk),
    .RESET                 (rst_n),
    .data_address_2DM      (addr),
    .MemRead_2DM           (mem_rd),
    .MemWrite_2DM          (mem_wr),
    .data_write_2DM        (wdata),
    .data_write_size_2DM   (wsize),
    .data_read_fDM         (rdata),
    .dBlkRead              (blk_rd),
    .dBlkWrite             (blk_wr),
    .block_write_2DM       (blk_wdata),
    .block_read_fDM        (blk_rdata),
    .block_read_fDM_valid  (rd_valid),
    .block_write_fDM_valid (wr_valid),
    .blk_busy              (busy)
  );

  // ---------------- scoreboard / model ----------------
  logic [255:0] exp_q[$];
  logic [31:0]  model [MW];
  int           n_vec = 0;
  int           n_err = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int midx(input logic [31:0] a);
    return int'((a >> 2) % MW);
  endfunction

  function automatic logic [255:0] model_blk(input logic [31:0] a);
    logic [255:0] r;
    int base;
    base = int'(a >> 5) * 8;
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = model[(base + i) % MW];
    return r;
  endfunction

  // Bytes off..off+n-1 written, last byte gets d[7:0]; bytes past 3 dropped.
  function automatic void model_word_write(input logic [31:0] a, input logic [31:0] d,
                                           input logic [1:0] sz);
    int n, k, w;
    n = (sz == 2'd0) ? 4 : int'(sz);
    w = midx(a);
    for (int b = 0; b < n; b++) begin
      k = int'(a[1:0]) + b;
      if (k < 4) model[w][8*(3-k) +: 8] = d[8*(n-1-b) +: 8];
    end
  endfunction

  function automatic void model_blk_write(input logic [31:0] a, input logic [255:0] d);
    int base;
    base = int'(a >> 5) * 8;
    for (int i = 0; i < 8; i++) model[(base + i) % MW] = d[255-32*i -: 32];
  endfunction

  // ---------------- driver tasks (start and end #1 after a posedge) ----------------
  task automatic word_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    addr = a; wdata = d; wsize = sz; mem_wr = 1'b1;
    @(posedge clk); #1;
    mem_wr = 1'b0;
    model_word_write(a, d, sz);
  endtask

  task automatic word_read(input string tag, input logic [31:0] a);
    exp_q.push_back({224'd0, model[midx(a)]});
    addr = a; mem_rd = 1'b1;
    #2;
    check(tag, {224'd0, rdata}, exp_q.pop_front());
    mem_rd = 1'b0;
    @(posedge clk); #1;
  endtask

  // Issue a block request, watch for the completion pulse, report latency.
  // hold : keep the request level high until completion
  // poke : wiggle request levels/address while BUSY (must be ignored)
  // side : word write (side_a, side_d) during the DONE cycle
  task automatic blk_op(input string tag, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [255:0] d,
                        input bit hold, input bit poke, input bit side,
                        input logic [31:0] side_a, input logic [31:0] side_d,
                        output int lat, output bit saw_rd, output bit saw_wr);
    lat = -1; saw_rd = 1'b0; saw_wr = 1'b0;
    addr = a; blk_rd = rd; blk_wr = wr; blk_wdata = d;
    @(posedge clk); #1;
    check({tag, "_busy"}, {255'd0, busy}, 256'd1);
    if (!hold) begin blk_rd = 1'b0; blk_wr = 1'b0; end
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (poke && cyc == 1) begin
        blk_rd = 1'b1; blk_wr = 1'b1; addr = 32'h3E0; blk_wdata = '0;
      end
      if (poke && cyc == 2) begin
        blk_rd = hold ? rd : 1'b0; blk_wr = hold ? wr : 1'b0; addr = a; blk_wdata = d;
      end
      @(posedge clk); #1;
      if (rd_valid || wr_valid) begin
        lat = cyc; saw_rd = rd_valid; saw_wr = wr_valid;
        break;
      end
    end
    if (lat < 0) check({tag, "_timeout"}, 256'd0, 256'd1);
    if (saw_rd) begin
      if (exp_q.size() == 0) check({tag, "_unexp_rd"}, 256'd1, 256'd0);
      else check({tag, "_rdata"}, blk_rdata, exp_q.pop_front());
    end
    blk_rd = 1'b0; blk_wr = 1'b0;
    if (side) begin addr = side_a; wdata = side_d; wsize = 2'd0; mem_wr = 1'b1; end
    @(posedge clk); #1;
    if (side) begin mem_wr = 1'b0; model_word_write(side_a, side_d, 2'd0); end
    check({tag, "_pulse_end"}, {254'd0, rd_valid, wr_valid}, 256'd0);
    check({tag, "_idle"}, {255'd0, busy}, 256'd0);
  endtask

  // ---------------- stimulus ----------------
  int           lat;
  bit           srd, swr;
  logic [255:0] held;
  logic [255:0] pat;

  initial begin
    rst_n = 1'b0; addr = '0; mem_rd = 1'b0; mem_wr = 1'b0; wdata = '0; wsize = '0;
    blk_rd = 1'b0; blk_wr = 1'b0; blk_wdata = '0;
    for (int i = 0; i < MW; i++) model[i] = 32'hx;

    // reset state
    @(posedge clk); @(posedge clk); #1;
    check("rst_busy", {255'd0, busy}, 256'd0);
    check("rst_valids", {254'd0, rd_valid, wr_valid}, 256'd0);
    check("rst_blk_rdata", blk_rdata, 256'd0);
    check("rst_rdata", {224'd0, rdata}, 256'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // word round trip, partial writes
    word_write(32'h40, 32'hDEADBEEF, 2'd0);
    word_read("word_rt", 32'h40);
    word_write(32'h40, 32'h11223344, 2'd0);
    word_write(32'h41, 32'h000000AB, 2'd1);
    word_read("part_b1", 32'h40);
    check("part_b1_const", {224'd0, model[midx(32'h40)]}, {224'd0, 32'h11AB3344});
    word_write(32'h42, 32'h0000CAFE, 2'd2);
    word_read("part_h2", 32'h40);
    word_write(32'h44, 32'h55667788, 2'd0);
    word_write(32'h44, 32'h00A1B2C3, 2'd3);
    word_read("part_t0", 32'h44);
    word_write(32'h45, 32'h00D4E5F6, 2'd3);
    word_read("part_t1", 32'h44);
    word_write(32'h47, 32'h0000003C, 2'd1);
    word_read("part_b3", 32'h44);

    // MemRead low returns zero
    addr = 32'h40; #2;
    check("rd_gate", {224'd0, rdata}, 256'd0);
    @(posedge clk); #1;

    // random in-word partial writes
    for (int i = 0; i < 8; i++) word_write(32'h80 + 32'(4*i), $urandom, 2'd0);
    for (int i = 0; i < 12; i++) begin
      int off, n;
      off = $urandom_range(0, 3);
      n   = $urandom_range(1, 4 - off);
      word_write(32'h80 + 32'(4*$urandom_range(0, 7)) + 32'(off), $urandom, 2'(n % 4));
    end
    for (int i = 0; i < 8; i++) word_read($sformatf("rand_w%0d", i), 32'h80 + 32'(4*i));

    // address wrap
    word_write(32'h1000, 32'hC0FFEE01, 2'd0);
    word_read("wrap", 32'h0);

    // block read latency, levels wiggled while busy must be ignored
    for (int i = 0; i < 8; i++) word_write(32'h100 + 32'(4*i), 32'(i + 1), 2'd0);
    exp_q.push_back(model_blk(32'h104));
    check("blk_exp_const", model_blk(32'h104),
          {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8});
    blk_op("blk_rd", 1'b1, 1'b0, 32'h104, '0, 1'b1, 1'b1, 1'b0, '0, '0, lat, srd, swr);
    check("blk_rd_lat", 256'(lat), 256'(LAT));
    check("blk_rd_kind", {254'd0, srd, swr}, 256'd2);
    held = blk_rdata;

    // simultaneous read+write: write wins
    word_write(32'h21C, 32'h12345678, 2'd0);
    pat = {32{8'hA5}};
    blk_op("blk_both", 1'b1, 1'b1, 32'h200, pat, 1'b0, 1'b0, 1'b0, '0, '0, lat, srd, swr);
    model_blk_write(32'h200, pat);
    check("blk_both_lat", 256'(lat), 256'(LAT));
    check("blk_both_kind", {254'd0, srd, swr}, 256'd1);
    word_read("blk_both_21c", 32'h21C);
    word_read("blk_both_200", 32'h200);
    check("blk_rdata_hold", blk_rdata, held);

    // block write beats word write to the same word on the same edge
    for (int i = 0; i < 8; i++) pat[255-32*i -: 32] = 32'h60000000 + 32'(i);
    blk_op("blk_vs_word", 1'b0, 1'b1, 32'h240, pat, 1'b0, 1'b0, 1'b1,
           32'h244, 32'hBAD0BAD0, lat, srd, swr);
    model_blk_write(32'h240, pat);
    word_read("blk_wins", 32'h244);

    // wrapped block read sees 0x100 block again
    exp_q.push_back(model_blk(32'h1100));
    blk_op("blk_wrap", 1'b1, 1'b0, 32'h1100, '0, 1'b0, 1'b0, 1'b0, '0, '0, lat, srd, swr);
    check("blk_wrap_lat", 256'(lat), 256'(LAT));

    // reset in the middle of a block write
    word_write(32'h300, 32'h0BADF00D, 2'd0);
    addr = 32'h300; blk_wr = 1'b1; blk_wdata = {32{8'h77}};
    @(posedge clk); #1;
    blk_wr = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {255'd0, busy}, 256'd0);
    check("mid_rst_blk_rdata", blk_rdata, 256'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    srd = 1'b0; swr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rd_valid) srd = 1'b1;
      if (wr_valid) swr = 1'b1;
    end
    check("mid_rst_no_pulse", {254'd0, srd, swr}, 256'd0);
    check("mid_rst_idle", {255'd0, busy}, 256'd0);
    word_read("mid_rst_keep", 32'h300);

    if (exp_q.size() != 0) check("sb_drain", 256'(exp_q.size()), 256'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
